// File: rtl/ddr3_app_arbiter.sv
// Two-client round-robin arbiter/sequencer for the MIG DDR3 app interface, with in-order read tag steering.
// Optional performance counters are built when DDR_ARB_PERF_EN is defined.
module ddr3_app_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 512,
  parameter int MASK_WIDTH = 64,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  init_calib_complete,
  input  logic                  c0_req_valid,
  output logic                  c0_req_ready,
  input  logic                  c0_req_write,
  input  logic [ADDR_WIDTH-1:0] c0_req_addr,
  input  logic [DATA_WIDTH-1:0] c0_req_wdata,
  input  logic [MASK_WIDTH-1:0] c0_req_wmask,
  output logic                  c0_rsp_valid,
  output logic [DATA_WIDTH-1:0] c0_rsp_data,
  input  logic                  c1_req_valid,
  output logic                  c1_req_ready,
  input  logic                  c1_req_write,
  input  logic [ADDR_WIDTH-1:0] c1_req_addr,
  input  logic [DATA_WIDTH-1:0] c1_req_wdata,
  input  logic [MASK_WIDTH-1:0] c1_req_wmask,
  output logic                  c1_rsp_valid,
  output logic [DATA_WIDTH-1:0] c1_rsp_data,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic [MASK_WIDTH-1:0] app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0] app_rd_data,
  input  logic                  app_rd_data_valid,
`ifdef DDR_ARB_PERF_EN
  output logic [31:0]           perf_rd_cnt,
  output logic [31:0]           perf_wr_cnt,
  output logic [31:0]           perf_stall_cnt,
`endif
  output logic                  err_rd_underflow
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  typedef enum logic [1:0] {WAIT_CAL, IDLE, ISSUE} state_t;

  state_t          state;
  logic            rr_last;
  logic            cur_id;
  logic            cur_write;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            tag_mem [TAG_DEPTH];
  logic [DATA_WIDTH-1:0] rsp_data;

  logic elig0, elig1, grant0, grant1, in_idle;
  logic cmd_acc, dat_acc, finish, push, pop, head_id;

  // A read is only eligible while a tag slot is free; writes never consume tags.
  assign elig0   = c0_req_valid && (c0_req_write || (count < CW'(TAG_DEPTH)));
  assign elig1   = c1_req_valid && (c1_req_write || (count < CW'(TAG_DEPTH)));
  assign grant0  = elig0 && (!elig1 || rr_last);
  assign grant1  = elig1 && (!elig0 || !rr_last);
  assign in_idle = (state == IDLE) && init_calib_complete;

  assign c0_req_ready = in_idle && grant0;
  assign c1_req_ready = in_idle && grant1;

  // app_en / app_wdf_wren double as the "handshake still pending" flags.
  assign cmd_acc = app_en && app_rdy;
  assign dat_acc = app_wdf_wren && app_wdf_rdy;
  assign finish  = (!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy);
  assign app_wdf_end = app_wdf_wren;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= WAIT_CAL;
      rr_last      <= 1'b1;
      cur_id       <= 1'b0;
      cur_write    <= 1'b0;
      app_addr     <= '0;
      app_cmd      <= 3'b000;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
    end else begin
      case (state)
        WAIT_CAL: begin
          if (init_calib_complete) state <= IDLE;
        end
        IDLE: begin
          if (!init_calib_complete) begin
            state <= WAIT_CAL;
          end else if (grant0 || grant1) begin
            cur_id       <= grant1;
            rr_last      <= grant1;
            cur_write    <= grant1 ? c1_req_write : c0_req_write;
            app_addr     <= grant1 ? c1_req_addr  : c0_req_addr;
            app_wdf_data <= grant1 ? c1_req_wdata : c0_req_wdata;
            app_wdf_mask <= grant1 ? c1_req_wmask : c0_req_wmask;
            app_cmd      <= (grant1 ? c1_req_write : c0_req_write) ? 3'b000 : 3'b001;
            app_en       <= 1'b1;
            app_wdf_wren <= grant1 ? c1_req_write : c0_req_write;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_acc) app_en <= 1'b0;
          if (dat_acc) app_wdf_wren <= 1'b0;
          if (finish) state <= IDLE;
        end
        default: state <= WAIT_CAL;
      endcase
    end
  end

  assign push    = cmd_acc && !cur_write;
  assign pop     = app_rd_data_valid && (count != '0);
  assign head_id = tag_mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) tag_mem[wr_ptr] <= cur_id;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      c0_rsp_valid     <= 1'b0;
      c1_rsp_valid     <= 1'b0;
      rsp_data         <= '0;
      err_rd_underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      c0_rsp_valid <= pop && !head_id;
      c1_rsp_valid <= pop && head_id;
      rsp_data     <= app_rd_data;
      if (app_rd_data_valid && (count == '0)) err_rd_underflow <= 1'b1;
    end
  end

  assign c0_rsp_data = rsp_data;
  assign c1_rsp_data = rsp_data;

`ifdef DDR_ARB_PERF_EN
  logic stall;
  assign stall = (state == ISSUE) &&
                 ((app_en && !app_rdy) || (app_wdf_wren && !app_wdf_rdy));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_rd_cnt    <= '0;
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (cmd_acc && !cur_write) perf_rd_cnt <= perf_rd_cnt + 1'b1;
      if (cmd_acc && cur_write)  perf_wr_cnt <= perf_wr_cnt + 1'b1;
      if (stall)                 perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Directed self-checking bench for ddr3_app_arbiter; inputs change and outputs are sampled around the falling edge.
module tb_ddr3_app_arbiter;
  localparam int AW = 30;
  localparam int DW = 512;
  localparam int MW = 64;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          init_calib_complete;
  logic          c0_req_valid, c0_req_ready, c0_req_write, c0_rsp_valid;
  logic [AW-1:0] c0_req_addr;
  logic [DW-1:0] c0_req_wdata, c0_rsp_data;
  logic [MW-1:0] c0_req_wmask;
  logic          c1_req_valid, c1_req_ready, c1_req_write, c1_rsp_valid;
  logic [AW-1:0] c1_req_addr;
  logic [DW-1:0] c1_req_wdata, c1_rsp_data;
  logic [MW-1:0] c1_req_wmask;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DW-1:0] app_wdf_data, app_rd_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_rd_data_valid;
  logic          err_rd_underflow;
`ifdef DDR_ARB_PERF_EN
  logic [31:0]   perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ddr3_app_arbiter dut (
    .CLK(CLK), .RST_N(RST_N), .init_calib_complete(init_calib_complete),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_write(c0_req_write),
    .c0_req_addr(c0_req_addr), .c0_req_wdata(c0_req_wdata), .c0_req_wmask(c0_req_wmask),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_write(c1_req_write),
    .c1_req_addr(c1_req_addr), .c1_req_wdata(c1_req_wdata), .c1_req_wmask(c1_req_wmask),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_data(c1_rsp_data),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
`ifdef DDR_ARB_PERF_EN
    .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .err_rd_underflow(err_rd_underflow)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rdata(input int i);
    return {16{32'hC0DE0000 + 32'(i)}};
  endfunction

`ifdef DDR_ARB_PERF_EN
  // One c0 transaction; app_rdy held low for the first 'stall' ISSUE cycles.
  task automatic one_txn(input logic wr, input int stall);
    @(negedge CLK);
    c0_req_valid = 1'b1; c0_req_write = wr;
    #1 check("perf_grant", c0_req_ready, 1);
    @(negedge CLK);
    c0_req_valid = 1'b0;
    app_rdy = (stall == 0);
    repeat (stall) @(negedge CLK);
    app_rdy = 1'b1;
  endtask
`endif

  int seen, n0, n1;

  initial begin
    RST_N = 1'b0; init_calib_complete = 1'b0;
    c0_req_valid = 1'b1; c0_req_write = 1'b0; c0_req_addr = 30'h10; c0_req_wdata = '0; c0_req_wmask = '0;
    c1_req_valid = 1'b1; c1_req_write = 1'b0; c1_req_addr = 30'h20; c1_req_wdata = '0; c1_req_wmask = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data = '0; app_rd_data_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    check("rst_app_en", app_en, 0);
    check("rst_wren", app_wdf_wren, 0);
    check("rst_ready0", c0_req_ready, 0);
    check("rst_cmd", app_cmd, 0);
    check("rst_err", err_rd_underflow, 0);
    @(negedge CLK) RST_N = 1'b1;

    // No traffic while uncalibrated
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK); #1;
      if (c0_req_ready || c1_req_ready || app_en) seen++;
    end
    check("nocal_quiet", seen, 0);

    // Calibration up: c0 first, then strict alternation
    @(negedge CLK) init_calib_complete = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (k == 8) begin c0_req_valid = 1'b0; c1_req_valid = 1'b0; end
      #1;
      if (k % 2 == 1) begin
        check($sformatf("rr_ready0_k%0d", k), c0_req_ready, (k % 4 == 1));
        check($sformatf("rr_ready1_k%0d", k), c1_req_ready, (k % 4 == 3));
        check($sformatf("rr_idle_en_k%0d", k), app_en, 0);
      end else begin
        check($sformatf("rr_app_en_k%0d", k), app_en, 1);
        check($sformatf("rr_addr_k%0d", k), app_addr, (k % 4 == 2) ? 30'h10 : 30'h20);
        check($sformatf("rr_cmd_k%0d", k), app_cmd, 3'b001);
      end
    end

    // Four returns steered c0,c1,c0,c1, one cycle late
    for (int i = 0; i <= 4; i++) begin
      @(negedge CLK);
      app_rd_data_valid = (i < 4);
      app_rd_data = rdata(i);
      #1;
      if (i == 0) begin
        check("rsp_not_early0", c0_rsp_valid, 0);
        check("rsp_not_early1", c1_rsp_valid, 0);
      end else begin
        check($sformatf("rsp_valid0_%0d", i - 1), c0_rsp_valid, ((i - 1) % 2 == 0));
        check($sformatf("rsp_valid1_%0d", i - 1), c1_rsp_valid, ((i - 1) % 2 == 1));
        check($sformatf("rsp_data_%0d", i - 1), c0_rsp_data, rdata(i - 1));
      end
    end
    app_rd_data_valid = 1'b0;

    // c1 write with app_wdf_rdy stalled 3 cycles
    @(negedge CLK);
    c1_req_valid = 1'b1; c1_req_write = 1'b1; c1_req_addr = 30'h100;
    c1_req_wdata = {64{8'hA5}}; c1_req_wmask = '0; app_wdf_rdy = 1'b0;
    #1 check("wr_ready1", c1_req_ready, 1);
    for (int w = 1; w <= 5; w++) begin
      @(negedge CLK);
      c1_req_valid = 1'b0;
      if (w == 4) app_wdf_rdy = 1'b1;
      #1;
      check($sformatf("wr_app_en_%0d", w), app_en, (w == 1));
      check($sformatf("wr_wren_%0d", w), app_wdf_wren, (w <= 4));
      check($sformatf("wr_end_%0d", w), app_wdf_end, (w <= 4));
      if (w == 1) begin
        check("wr_cmd", app_cmd, 3'b000);
        check("wr_addr", app_addr, 30'h100);
        check("wr_data", app_wdf_data, {64{8'hA5}});
        check("wr_mask", app_wdf_mask, 0);
      end
    end

    // Fill all 16 tags from c0
    c0_req_write = 1'b0; c0_req_addr = 30'h40;
    n0 = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge CLK);
      if (i == 1) c0_req_valid = 1'b1;
      #1;
      if (c0_req_ready) n0++;
    end
    check("fill_grants", n0, 16);
    @(negedge CLK);
    c1_req_valid = 1'b1; c1_req_write = 1'b1;
    #1;
    check("full_ready0", c0_req_ready, 0);
    check("full_wr_ready1", c1_req_ready, 1);
    @(negedge CLK) c1_req_valid = 1'b0;
    @(negedge CLK);
    app_rd_data_valid = 1'b1; app_rd_data = rdata(9);
    #1;
    check("full_still_blocked", c0_req_ready, 0);
    check("full_no_en", app_en, 0);
    @(negedge CLK);
    app_rd_data_valid = 1'b0;
    #1;
    check("after_pop_ready0", c0_req_ready, 1);
    check("after_pop_rsp0", c0_rsp_valid, 1);
    check("after_pop_rsp1", c1_rsp_valid, 0);
    @(negedge CLK) c0_req_valid = 1'b0;

    // Drain the 16 outstanding c0 reads
    n0 = 0; n1 = 0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge CLK);
      app_rd_data_valid = (i < 16);
      #1;
      if (c0_rsp_valid) n0++;
      if (c1_rsp_valid) n1++;
    end
    check("drain_c0", n0, 16);
    check("drain_c1", n1, 0);
    check("drain_no_err", err_rd_underflow, 0);

    // Underflow is sticky and produces no response
    @(negedge CLK) app_rd_data_valid = 1'b1;
    @(negedge CLK);
    app_rd_data_valid = 1'b0;
    #1;
    check("uf_err", err_rd_underflow, 1);
    check("uf_no_rsp0", c0_rsp_valid, 0);
    check("uf_no_rsp1", c1_rsp_valid, 0);
    repeat (3) @(negedge CLK);
    #1 check("uf_sticky", err_rd_underflow, 1);

    // Async reset in the middle of a stalled ISSUE
    @(negedge CLK);
    c0_req_valid = 1'b1; app_rdy = 1'b0;
    #1 check("mid_ready0", c0_req_ready, 1);
    @(negedge CLK);
    c0_req_valid = 1'b0;
    #1 check("mid_app_en", app_en, 1);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_en", app_en, 0);
    check("mid_rst_addr", app_addr, 0);
    check("mid_rst_cmd", app_cmd, 0);
    check("mid_rst_err", err_rd_underflow, 0);
    @(negedge CLK);
    RST_N = 1'b1; app_rdy = 1'b1;
    @(negedge CLK) app_rd_data_valid = 1'b1;
    @(negedge CLK);
    app_rd_data_valid = 1'b0;
    #1;
    check("post_rst_uf_err", err_rd_underflow, 1);
    check("post_rst_no_rsp", c0_rsp_valid, 0);

`ifdef DDR_ARB_PERF_EN
    one_txn(1'b0, 7);
    for (int i = 0; i < 4; i++) one_txn(1'b0, 0);
    for (int i = 0; i < 3; i++) one_txn(1'b1, 0);
    @(negedge CLK);
    #1;
    check("perf_rd", perf_rd_cnt, 5);
    check("perf_wr", perf_wr_cnt, 3);
    check("perf_stall", perf_stall_cnt, 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
